// File: rtl/reg_file_p.sv
// reg_file_p: parametrised 2-read/1-write register file with byte-enable
// writes, optional write-to-read bypass, optional hardwired zero register,
// and a sequenced bulk-clear engine that walks the array one entry per cycle.
//
// Handshake note: clr_req is sampled only in IDLE (pulse or level both work);
// clr_busy is high for exactly DEPTH cycles while entries are being zeroed;
// clr_done pulses for one cycle after the last entry is cleared. Writes are
// accepted only in IDLE; a write with any byte enabled during CLEAR is dropped
// and flagged on wr_drop in that same cycle.
module reg_file_p #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                cr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr_w,
  input  logic [DATA_W-1:0]   di,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [ADDR_W-1:0]   addr_b,
  output logic [DATA_W-1:0]   qa,
  output logic [DATA_W-1:0]   qb,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                wr_drop,
  output logic                clr_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic                done_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                idle_wr;
  logic                wr_commit;

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     en
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int j = 0; j < NB; j++) begin
      if (en[j]) r[8*j +: 8] = new_w[8*j +: 8];
    end
    return r;
  endfunction

  // Write qualification: only IDLE writes count, and entry 0 is read-only
  // when it is the hardwired zero register.
  always_comb begin
    idle_wr   = we && (state == IDLE);
    wr_commit = idle_wr && !((ZERO_REG != 0) && (addr_w == '0));
    wr_drop   = we && (be != '0) && (state == CLEAR);
    clr_busy  = (state == CLEAR);
    clr_state = (state == CLEAR);
  end

  // Clear FSM state, walk pointer and done pulse.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_done <= done_nxt;
    end
  end

  // Next-state logic; the pointer only returns to 0 through the CLEAR exit.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Storage array: async wipe on reset, one entry per cycle in CLEAR,
  // byte-enabled writes in IDLE.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_commit) begin
      for (int j = 0; j < NB; j++) begin
        if (be[j]) mem[addr_w][8*j +: 8] <= di[8*j +: 8];
      end
    end
  end

  // Read ports: array lookup, optional same-cycle forward of the pending
  // write, and the zero register overriding everything.
  always_comb begin
    qa = mem[addr_a];
    qb = mem[addr_b];
    if ((BYPASS != 0) && idle_wr && (addr_a == addr_w))
      qa = merge_bytes(mem[addr_w], di, be);
    if ((BYPASS != 0) && idle_wr && (addr_b == addr_w))
      qb = merge_bytes(mem[addr_w], di, be);
    if ((ZERO_REG != 0) && (addr_a == '0)) qa = '0;
    if ((ZERO_REG != 0) && (addr_b == '0)) qb = '0;
  end

endmodule

// File: tb/tb_reg_file_p.sv
// tb_reg_file_p: directed checks of reg_file_p with the default 8x32 build,
// a no-bypass 8x32 build sharing the same stimulus, and a 32x64 build.
module tb_reg_file_p;

  logic        clk;
  logic        cr;
  logic        we;
  logic [3:0]  be;
  logic [2:0]  addr_w;
  logic [31:0] di;
  logic [2:0]  addr_a;
  logic [2:0]  addr_b;
  logic        clr_req;
  logic [31:0] qa, qb, qa_nb, qb_nb;
  logic        clr_busy, clr_done, wr_drop, clr_state;
  logic        busy_nb, done_nb, drop_nb, state_nb;

  logic        w_we;
  logic [7:0]  w_be;
  logic [4:0]  w_addr_w, w_addr_a, w_addr_b;
  logic [63:0] w_di, w_qa, w_qb;
  logic        w_clr_req, w_busy, w_done, w_drop, w_state;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_p dut (
    .clk(clk), .cr(cr), .we(we), .be(be), .addr_w(addr_w), .di(di),
    .addr_a(addr_a), .addr_b(addr_b), .qa(qa), .qb(qb), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop),
    .clr_state(clr_state)
  );

  reg_file_p #(.BYPASS(0)) dut_nb (
    .clk(clk), .cr(cr), .we(we), .be(be), .addr_w(addr_w), .di(di),
    .addr_a(addr_a), .addr_b(addr_b), .qa(qa_nb), .qb(qb_nb), .clr_req(clr_req),
    .clr_busy(busy_nb), .clr_done(done_nb), .wr_drop(drop_nb),
    .clr_state(state_nb)
  );

  reg_file_p #(.DATA_W(64), .ADDR_W(5)) dut_w (
    .clk(clk), .cr(cr), .we(w_we), .be(w_be), .addr_w(w_addr_w), .di(w_di),
    .addr_a(w_addr_a), .addr_b(w_addr_b), .qa(w_qa), .qb(w_qb),
    .clr_req(w_clr_req), .clr_busy(w_busy), .clr_done(w_done),
    .wr_drop(w_drop), .clr_state(w_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; addr_w = a; di = d; be = b;
    step();
    we = 1'b0; be = 4'h0;
  endtask

  task automatic fill(input logic [31:0] d);
    for (int k = 0; k < 8; k++) wr(3'(k), d, 4'hF);
  endtask

  task automatic test_reset();
    cr = 1'b0; we = 1'b0; be = 4'h0; addr_w = 3'd0; di = 32'h0;
    addr_a = 3'd5; addr_b = 3'd1; clr_req = 1'b0;
    w_we = 1'b0; w_be = 8'h0; w_addr_w = 5'd0; w_di = 64'h0;
    w_addr_a = 5'd31; w_addr_b = 5'd7; w_clr_req = 1'b0;
    #2;
    n_cmp++; if (qa !== 32'h0) begin n_bad++; $display("FAIL reset_qa: got %h want %h", qa, 32'h0); end
    n_cmp++; if (qb !== 32'h0) begin n_bad++; $display("FAIL reset_qb: got %h want %h", qb, 32'h0); end
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", clr_busy); end
    n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", clr_done); end
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b want 0", wr_drop); end
    n_cmp++; if (w_qa !== 64'h0) begin n_bad++; $display("FAIL reset_wide_qa: got %h want 0", w_qa); end
    step();
    step();
    cr = 1'b1;
    #1;
  endtask

  task automatic test_write_read();
    logic [31:0] exp;
    for (int k = 1; k < 8; k++) wr(3'(k), 32'hDEADBEEF, 4'hF);
    // Write to the zero register: silently discarded, bypass suppressed.
    we = 1'b1; addr_w = 3'd0; di = 32'hDEADBEEF; be = 4'hF; addr_a = 3'd0; addr_b = 3'd0;
    #1;
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL zero_wr_drop: got %b want 0", wr_drop); end
    n_cmp++; if (qa !== 32'h0) begin n_bad++; $display("FAIL zero_bypass_qa: got %h want 0", qa); end
    step();
    we = 1'b0; be = 4'h0;
    for (int k = 0; k < 8; k++) begin
      addr_a = 3'(k); addr_b = 3'(k);
      #1;
      exp = (k == 0) ? 32'h0 : 32'hDEADBEEF;
      n_cmp++; if (qa !== exp) begin n_bad++; $display("FAIL rd_a[%0d]: got %h want %h", k, qa, exp); end
      n_cmp++; if (qb !== exp) begin n_bad++; $display("FAIL rd_b[%0d]: got %h want %h", k, qb, exp); end
    end
    addr_a = 3'd2; addr_b = 3'd0;
    #1;
    n_cmp++; if (qa !== 32'hDEADBEEF) begin n_bad++; $display("FAIL split_a: got %h want DEADBEEF", qa); end
    n_cmp++; if (qb !== 32'h0) begin n_bad++; $display("FAIL split_b: got %h want 0", qb); end
  endtask

  task automatic test_byte_enable();
    wr(3'd3, 32'h11223344, 4'hF);
    we = 1'b1; addr_w = 3'd3; di = 32'hAABBCCDD; be = 4'b0101; addr_a = 3'd3; addr_b = 3'd3;
    #1;
    n_cmp++; if (qa !== 32'h11BB33DD) begin n_bad++; $display("FAIL bypass_qa: got %h want 11BB33DD", qa); end
    n_cmp++; if (qb !== 32'h11BB33DD) begin n_bad++; $display("FAIL bypass_qb: got %h want 11BB33DD", qb); end
    n_cmp++; if (qa_nb !== 32'h11223344) begin n_bad++; $display("FAIL nobypass_qa: got %h want 11223344", qa_nb); end
    step();
    we = 1'b0; be = 4'h0;
    #1;
    n_cmp++; if (qa !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_commit: got %h want 11BB33DD", qa); end
    n_cmp++; if (qa_nb !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_commit_nb: got %h want 11BB33DD", qa_nb); end
    // we with no byte enables: no-op, not a drop.
    we = 1'b1; di = 32'h0; be = 4'h0;
    #1;
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL be0_drop: got %b want 0", wr_drop); end
    step();
    we = 1'b0;
    #1;
    n_cmp++; if (qa !== 32'h11BB33DD) begin n_bad++; $display("FAIL be0_keep: got %h want 11BB33DD", qa); end
  endtask

  task automatic test_clear();
    logic [31:0] exp;
    fill(32'hFFFFFFFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      addr_a = 3'(k); addr_b = 3'((k + 1) % 8);
      #1;
      exp = (k == 0) ? 32'h0 : 32'hFFFFFFFF;
      n_cmp++; if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy[%0d]: got %b want 1", k, clr_busy); end
      n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL clr_done_early[%0d]: got %b want 0", k, clr_done); end
      n_cmp++; if (qa !== exp) begin n_bad++; $display("FAIL clr_before[%0d]: got %h want %h", k, qa, exp); end
      step();
      n_cmp++; if (qa !== 32'h0) begin n_bad++; $display("FAIL clr_after[%0d]: got %h want 0", k, qa); end
    end
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy_end: got %b want 0", clr_busy); end
    n_cmp++; if (clr_done !== 1'b1) begin n_bad++; $display("FAIL clr_done: got %b want 1", clr_done); end
    step();
    n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL clr_done_pulse: got %b want 0", clr_done); end
    for (int k = 0; k < 8; k++) begin
      addr_a = 3'(k);
      #1;
      n_cmp++; if (qa !== 32'h0) begin n_bad++; $display("FAIL clr_all[%0d]: got %h want 0", k, qa); end
    end
  endtask

  task automatic test_clear_write();
    int n;
    fill(32'hFFFFFFFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    // Walk is at entry 2: this write must be dropped, and the clr_req ignored.
    we = 1'b1; addr_w = 3'd5; di = 32'h5; be = 4'hF; addr_a = 3'd5; clr_req = 1'b1;
    #1;
    n_cmp++; if (wr_drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse: got %b want 1", wr_drop); end
    n_cmp++; if (qa !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL drop_nobypass: got %h want FFFFFFFF", qa); end
    step();
    we = 1'b0; be = 4'h0; clr_req = 1'b0;
    #1;
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL drop_end: got %b want 0", wr_drop); end
    n = 0;
    while (clr_done !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL drop_clr_len: got %0d want 5", n); end
    n_cmp++; if (qa !== 32'h0) begin n_bad++; $display("FAIL drop_entry5: got %h want 0", qa); end
    step();
    // Write and clear request together in IDLE: write commits, then gets wiped.
    we = 1'b1; addr_w = 3'd5; di = 32'h5; be = 4'hF; clr_req = 1'b1;
    #1;
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL same_drop: got %b want 0", wr_drop); end
    n_cmp++; if (qa !== 32'h5) begin n_bad++; $display("FAIL same_bypass: got %h want 5", qa); end
    step();
    we = 1'b0; be = 4'h0; clr_req = 1'b0;
    #1;
    n_cmp++; if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL same_busy: got %b want 1", clr_busy); end
    n_cmp++; if (qa !== 32'h5) begin n_bad++; $display("FAIL same_commit: got %h want 5", qa); end
    n = 0;
    while (clr_done !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL same_clr_len: got %0d want 8", n); end
    n_cmp++; if (qa !== 32'h0) begin n_bad++; $display("FAIL same_wiped: got %h want 0", qa); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    clr_req = 1'b1;
    step();
    n = 0;
    while (clr_done !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL b2b_len1: got %0d want 8", n); end
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: got %b want 0", clr_busy); end
    step();
    n_cmp++; if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_reenter: got %b want 1", clr_busy); end
    n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_low: got %b want 0", clr_done); end
    clr_req = 1'b0;
    n = 0;
    while (clr_done !== 1'b1 && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL b2b_len2: got %0d want 8", n); end
    step();
  endtask

  task automatic test_reset_mid_clear();
    int n_done;
    fill(32'hFFFFFFFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (4) step();
    addr_a = 3'd6; addr_b = 3'd3;
    #1;
    n_cmp++; if (qa !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mid_unwalked: got %h want FFFFFFFF", qa); end
    n_cmp++; if (qb !== 32'h0) begin n_bad++; $display("FAIL mid_walked: got %h want 0", qb); end
    n_cmp++; if (clr_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", clr_busy); end
    cr = 1'b0;
    #1;
    n_cmp++; if (qa !== 32'h0) begin n_bad++; $display("FAIL abort_qa: got %h want 0", qa); end
    n_cmp++; if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", clr_busy); end
    step();
    cr = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (clr_done === 1'b1 || clr_busy === 1'b1) n_done++;
      step();
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
    wr(3'd2, 32'h1, 4'hF);
    addr_a = 3'd2;
    #1;
    n_cmp++; if (qa !== 32'h1) begin n_bad++; $display("FAIL post_abort_wr: got %h want 1", qa); end
  endtask

  task automatic test_wide();
    int n;
    w_we = 1'b1; w_addr_w = 5'd31; w_di = 64'h0123456789ABCDEF; w_be = 8'hFF;
    w_addr_b = 5'd31; w_addr_a = 5'd0;
    step();
    w_we = 1'b0; w_be = 8'h0;
    #1;
    n_cmp++; if (w_qb !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL wide_qb: got %h want 0123456789ABCDEF", w_qb); end
    n_cmp++; if (w_qa !== 64'h0) begin n_bad++; $display("FAIL wide_zero: got %h want 0", w_qa); end
    w_clr_req = 1'b1;
    step();
    w_clr_req = 1'b0;
    n = 0;
    while (w_busy === 1'b1 && n < 100) begin n++; step(); end
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL wide_busy_len: got %0d want 32", n); end
    n_cmp++; if (w_done !== 1'b1) begin n_bad++; $display("FAIL wide_done: got %b want 1", w_done); end
    n_cmp++; if (w_qb !== 64'h0) begin n_bad++; $display("FAIL wide_cleared: got %h want 0", w_qb); end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_clear();
    test_clear_write();
    test_back_to_back();
    test_reset_mid_clear();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
